spi_target: RTL and testbench

//  SPI target (slave), mode 0 (CPOL=0, CPHA=0), MSB first, byte-oriented.

---
 rtl/spi_target_pkg.sv | 8 +
 rtl/spi_target_sync.sv | 36 +++
 rtl/spi_target.sv | 164 ++++++++++++++++
 tb/tb_spi_target.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared constants and state encoding for the mode-0 SPI target.
package spi_target_pkg;
  localparam int   BYTE_W   = 8;
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
endpackage

// File: rtl/spi_target_sync.sv
// Async-pin synchronizer; level and registered edge pulses appear STAGES+1 cycles after the pin.
module spi_target_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_chain;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;

  // Level is delayed one extra flop so it stays aligned with the edge pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_chain <= {STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
      r_prev  <= r_chain[STAGES-1];
      r_rise  <= r_chain[STAGES-1] & ~r_prev;
      r_fall  <= ~r_chain[STAGES-1] & r_prev;
    end
  end

  assign o_q    = r_prev;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
endmodule

// File: rtl/spi_target.sv
// Mode-0 SPI target, oversampled in i_clk; RX held until i_rx_ready (overrun drops), TX holding reg.
// Optional SPI_TARGET_BYTECNT_EN adds o_byte_count (bytes completed in the current/last frame).
module spi_target
  import spi_target_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] DEFAULT_TX  = 8'hFF,
  parameter int                BCNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  output logic [BYTE_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  input  logic [BYTE_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic              o_rx_overrun,
  output logic              o_tx_underrun,
  output logic              o_frame_end
`ifdef SPI_TARGET_BYTECNT_EN
  ,output logic [BCNT_W-1:0] o_byte_count
`endif
);
  localparam int CNT_W = $clog2(BYTE_W);
  localparam int SET_W = $clog2(SYNC_STAGES + 2);

  logic w_sclk_lvl_unused, w_sclk_rise, w_sclk_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sync_sclk (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sclk),
    .o_q(w_sclk_lvl_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_cs_n),
    .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
  spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_mosi),
    .o_q(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused));

  state_t            r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [BYTE_W-1:0] r_shift_rx, r_shift_tx, r_hold, r_rx_data;
  logic              r_hold_full, r_reload, r_armed, r_miso, r_miso_oe, r_rx_valid;
  logic              r_rx_overrun, r_tx_underrun, r_frame_end;
  logic [SET_W-1:0]  r_settle;

  logic              w_sample, w_drive, w_start, w_capture, w_done, w_load;
  logic [BYTE_W-1:0] w_rx_byte, w_load_byte;

  assign w_sample    = (SPI_CPOL ^ SPI_CPHA) ? w_sclk_fall : w_sclk_rise;
  assign w_drive     = (SPI_CPOL ^ SPI_CPHA) ? w_sclk_rise : w_sclk_fall;
  assign w_start     = (r_state == IDLE) & w_cs_fall & r_armed;
  assign w_capture   = ((r_state != IDLE) | w_start) & w_sample & ~w_cs_rise;
  assign w_done      = w_capture & (r_bit_cnt == CNT_W'(BYTE_W - 1));
  assign w_rx_byte   = {r_shift_rx[BYTE_W-2:0], w_mosi};
  assign w_load      = ~w_cs_rise & ((r_state == LOAD) | ((r_state == SHIFT) & w_drive & r_reload));
  assign w_load_byte = r_hold_full ? r_hold : DEFAULT_TX;

  // r_armed blocks joining a frame already in progress when reset releases with cs_n low.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_shift_rx    <= '0;
      r_shift_tx    <= '0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_reload      <= 1'b0;
      r_armed       <= 1'b0;
      r_settle      <= '0;
      r_miso        <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_end   <= 1'b0;
    end else begin
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_end   <= 1'b0;

      if (r_settle != SET_W'(SYNC_STAGES + 1)) r_settle <= r_settle + 1'b1;
      else if (w_cs_q)                         r_armed  <= 1'b1;

      if (w_load) begin
        r_shift_tx <= w_load_byte;
        r_miso     <= w_load_byte[BYTE_W-1];
        r_miso_oe  <= 1'b1;
        if (r_hold_full) r_hold_full   <= 1'b0;
        else             r_tx_underrun <= 1'b1;
      end
      if (i_tx_valid && !r_hold_full) begin
        r_hold      <= i_tx_data;
        r_hold_full <= 1'b1;
      end

      if (r_rx_valid && i_rx_ready) r_rx_valid <= 1'b0;
      if (w_capture) begin
        r_shift_rx <= w_rx_byte;
        r_bit_cnt  <= r_bit_cnt + 1'b1;
      end
      if (w_done) begin
        r_reload <= 1'b1;
        if (!r_rx_valid || i_rx_ready) begin
          r_rx_data  <= w_rx_byte;
          r_rx_valid <= 1'b1;
        end else begin
          r_rx_overrun <= 1'b1;
        end
      end

      if (w_cs_rise) begin
        r_state     <= IDLE;
        r_miso_oe   <= 1'b0;
        r_bit_cnt   <= '0;
        r_reload    <= 1'b0;
        r_frame_end <= 1'b1;
      end else begin
        case (r_state)
          IDLE:  if (w_start) r_state <= LOAD;
          LOAD:  r_state <= SHIFT;
          SHIFT: if (w_drive) begin
            if (r_reload) begin
              r_reload <= 1'b0;
            end else begin
              r_miso     <= r_shift_tx[BYTE_W-2];
              r_shift_tx <= {r_shift_tx[BYTE_W-2:0], 1'b0};
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef SPI_TARGET_BYTECNT_EN
  logic [BCNT_W-1:0] r_byte_count;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                     r_byte_count <= '0;
    else if (w_start)                 r_byte_count <= '0;
    else if (w_done && !(&r_byte_count)) r_byte_count <= r_byte_count + 1'b1;
  end
  assign o_byte_count = r_byte_count;
`else
  localparam int bcnt_w_unused = BCNT_W;
`endif

  assign o_miso        = r_miso;
  assign o_miso_oe     = r_miso_oe;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_ready    = ~r_hold_full;
  assign o_rx_overrun  = r_rx_overrun;
  assign o_tx_underrun = r_tx_underrun;
  assign o_frame_end   = r_frame_end;
endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: SPI pins change on i_clk negedges, sclk = clk/8.
module tb_spi_target;
  logic       i_clk = 1'b0;
  logic       i_rst_n, i_sclk, i_cs_n, i_mosi;
  logic       o_miso, o_miso_oe, o_rx_valid, i_rx_ready, i_tx_valid, o_tx_ready;
  logic       o_rx_overrun, o_tx_underrun, o_frame_end;
  logic [7:0] o_rx_data, i_tx_data;
`ifdef SPI_TARGET_BYTECNT_EN
  logic [15:0] o_byte_count;
`endif

  spi_target dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi),
    .o_miso(o_miso), .o_miso_oe(o_miso_oe), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
    .i_rx_ready(i_rx_ready), .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid),
    .o_tx_ready(o_tx_ready), .o_rx_overrun(o_rx_overrun), .o_tx_underrun(o_tx_underrun),
    .o_frame_end(o_frame_end)
`ifdef SPI_TARGET_BYTECNT_EN
    , .o_byte_count(o_byte_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, errors = 0;
  int n_under = 0, n_over = 0, n_fend = 0, n_rxhs = 0;
  int u0, o0, f0, h0;
  logic [7:0] rx_q[$], miso_q[$];
  logic [7:0] m_sh = 8'h00;
  int m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // RX monitor and pulse counters.
  always @(negedge i_clk) begin
    if (o_tx_underrun) n_under++;
    if (o_rx_overrun)  n_over++;
    if (o_frame_end)   n_fend++;
    if (o_rx_valid && i_rx_ready) begin
      n_rxhs++;
      if (rx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexpected actual %0h required none", o_rx_data);
      end else begin
        check("rx_data", o_rx_data, rx_q.pop_front());
      end
    end
  end

  // MISO monitor: controller samples on sclk rise, whole bytes only.
  always @(posedge i_sclk) begin
    if (!i_cs_n && o_miso_oe) begin
      m_sh = {m_sh[6:0], o_miso};
      m_cnt++;
      if (m_cnt == 8) begin
        m_cnt = 0;
        if (miso_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL miso_unexpected actual %0h required none", m_sh);
        end else begin
          check("miso_byte", m_sh, miso_q.pop_front());
        end
      end
    end else begin
      m_cnt = 0;
    end
  end
  always @(posedge i_cs_n) m_cnt = 0;

  task automatic half();
    repeat (4) @(negedge i_clk);
  endtask

  task automatic cs_low();
    @(negedge i_clk);
    i_cs_n = 1'b0;
    half(); half();
  endtask

  // Last sclk fall coincides with cs_n rise, so no reload follows the final byte.
  task automatic spi_bits(input logic [7:0] b, input int nbits, input bit end_frame);
    for (int i = 7; i >= 8 - nbits; i--) begin
      i_mosi = b[i];
      half();
      i_sclk = 1'b1;
      half();
      i_sclk = 1'b0;
      if (end_frame && i == 8 - nbits) i_cs_n = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input int n);
    logic [7:0] bb [4];
    bb = '{b0, b1, b2, b3};
    for (int i = 0; i < n; i++) spi_bits(bb[i], 8, i == n - 1);
    repeat (20) @(negedge i_clk);
  endtask

  task automatic queue_tx(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_tx_valid = 1'b1; i_tx_data = b;
    @(posedge i_clk); #1;
    i_tx_valid = 1'b0;
  endtask

  task automatic snap();
    u0 = n_under; o0 = n_over; f0 = n_fend; h0 = n_rxhs;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, o_miso, 0);
    check({tag, "_oe"}, o_miso_oe, 0);
    check({tag, "_rx_valid"}, o_rx_valid, 0);
    check({tag, "_rx_data"}, o_rx_data, 0);
    check({tag, "_tx_ready"}, o_tx_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0; i_sclk = 1'b0; i_cs_n = 1'b1; i_mosi = 1'b0;
    i_rx_ready = 1'b1; i_tx_valid = 1'b0; i_tx_data = 8'h00;
    repeat (5) @(negedge i_clk);
    check_reset_outputs("reset");
    check("reset_underrun", o_tx_underrun, 0);
    check("reset_overrun", o_rx_overrun, 0);
    check("reset_frame_end", o_frame_end, 0);
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    repeat (10) @(negedge i_clk);

    // 1: held TX A5, receive 3C
    queue_tx(8'hA5);
    check("t1_tx_ready_full", o_tx_ready, 0);
    miso_q.push_back(8'hA5); rx_q.push_back(8'h3C);
    snap();
    cs_low();
    check("t1_tx_ready_after_load", o_tx_ready, 1);
    check("t1_oe_active", o_miso_oe, 1);
    send(8'h3C, 8'h00, 8'h00, 8'h00, 1);
    check("t1_underrun", n_under - u0, 0);
    check("t1_frame_end", n_fend - f0, 1);
    check("t1_rx_once", n_rxhs - h0, 1);
    check("t1_oe_idle", o_miso_oe, 0);

    // 2: nothing queued, 3 bytes -> DEFAULT_TX each time
    for (int i = 0; i < 3; i++) miso_q.push_back(8'hFF);
    rx_q.push_back(8'h01); rx_q.push_back(8'h02); rx_q.push_back(8'h03);
    snap();
    cs_low();
    send(8'h01, 8'h02, 8'h03, 8'h00, 3);
    check("t2_underrun", n_under - u0, 3);
    check("t2_rx_count", n_rxhs - h0, 3);

    // 3: RX stalled -> second byte dropped
    @(posedge i_clk); #1 i_rx_ready = 1'b0;
    miso_q.push_back(8'hFF); miso_q.push_back(8'hFF);
    snap();
    cs_low();
    send(8'h11, 8'h22, 8'h00, 8'h00, 2);
    check("t3_overrun", n_over - o0, 1);
    check("t3_rx_valid_held", o_rx_valid, 1);
    check("t3_rx_data_held", o_rx_data, 8'h11);
    rx_q.push_back(8'h11);
    @(posedge i_clk); #1 i_rx_ready = 1'b1;
    repeat (5) @(negedge i_clk);
    check("t3_rx_once", n_rxhs - h0, 1);
    check("t3_rx_valid_drop", o_rx_valid, 0);

    // 4: abort after 5 rises, then a clean frame
    snap();
    cs_low();
    spi_bits(8'hA0, 5, 1'b1);
    repeat (20) @(negedge i_clk);
    check("t4_oe", o_miso_oe, 0);
    check("t4_no_rx", n_rxhs - h0, 0);
    check("t4_rx_valid", o_rx_valid, 0);
    check("t4_frame_end", n_fend - f0, 1);
    queue_tx(8'h5A);
    miso_q.push_back(8'h5A); rx_q.push_back(8'h5A);
    cs_low();
    send(8'h5A, 8'h00, 8'h00, 8'h00, 1);
    check("t4_rx_next", n_rxhs - h0, 1);

    // 5: reset mid-byte, release with cs_n still low
    snap();
    cs_low();
    spi_bits(8'hE7, 3, 1'b0);
    @(posedge i_clk); #1 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("t5_in_reset");
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    spi_bits(8'h1F, 5, 1'b0);
    repeat (10) @(negedge i_clk);
    check("t5_oe_ignored", o_miso_oe, 0);
    check("t5_rx_valid_ignored", o_rx_valid, 0);
    check("t5_no_rx", n_rxhs - h0, 0);
    @(negedge i_clk) i_cs_n = 1'b1;
    repeat (20) @(negedge i_clk);
    queue_tx(8'h96);
    miso_q.push_back(8'h96); rx_q.push_back(8'hC3);
    cs_low();
    send(8'hC3, 8'h00, 8'h00, 8'h00, 1);
    check("t5_rx_next", n_rxhs - h0, 1);

`ifdef SPI_TARGET_BYTECNT_EN
    // 6: byte counter
    for (int i = 0; i < 4; i++) miso_q.push_back(8'hFF);
    rx_q.push_back(8'h10); rx_q.push_back(8'h20); rx_q.push_back(8'h30); rx_q.push_back(8'h40);
    cs_low();
    send(8'h10, 8'h20, 8'h30, 8'h40, 4);
    check("t6_count", o_byte_count, 4);
    miso_q.push_back(8'hFF); rx_q.push_back(8'h77);
    cs_low();
    check("t6_count_clear", o_byte_count, 0);
    send(8'h77, 8'h00, 8'h00, 8'h00, 1);
    check("t6_count_one", o_byte_count, 1);
`endif

    check("rx_queue_empty", rx_q.size(), 0);
    check("miso_queue_empty", miso_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
